// File: rtl/sdram_responder_if.sv
// SDRAM master-port bundle between the filter pipeline (master) and the responder (slave).
// Latency: none, wires only.
// Backpressure: waitrequest from the slave; the master holds or reissues a strobe while it is high.
//
// Signals:
//   sdram_read_en / sdram_write_en : one-cycle request strobes (master -> slave)
//   address_sdram                  : 26-bit word address (master -> slave)
//   writeData_sdram                : 32-bit write data (master -> slave)
//   data_sdram                     : 32-bit read data (slave -> master)
//   sdram_datareadvalid            : one-cycle read-data valid pulse (slave -> master)
//   waitrequest                    : registered stall, high while requests are refused (slave -> master)
//   err                            : sticky error flags (slave -> master)
interface sdram_responder_if;
  logic        sdram_read_en;
  logic        sdram_write_en;
  logic [25:0] address_sdram;
  logic [31:0] writeData_sdram;
  logic [31:0] data_sdram;
  logic        sdram_datareadvalid;
  logic        waitrequest;
  logic [1:0]  err;

  modport master (
    output sdram_read_en,
    output sdram_write_en,
    output address_sdram,
    output writeData_sdram,
    input  data_sdram,
    input  sdram_datareadvalid,
    input  waitrequest,
    input  err
  );

  modport slave (
    input  sdram_read_en,
    input  sdram_write_en,
    input  address_sdram,
    input  writeData_sdram,
    output data_sdram,
    output sdram_datareadvalid,
    output waitrequest,
    output err
  );
endinterface

// File: rtl/sdram_responder.sv
// SDRAM slave responder: word memory behind the master port, with periodic refresh stalls.
// Latency: READ_LATENCY cycles from read acceptance to the read-data valid pulse; writes land at acceptance.
// Backpressure: waitrequest is high for REFRESH_CYCLES every REFRESH_PERIOD serve cycles; strobes then are ignored.
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   n_rst  : asynchronous active-low reset
//   sdram  : slave side of sdram_responder_if (strobes, address, write data in;
//            read data, valid pulse, waitrequest, sticky err out)
module sdram_responder #(
  parameter int MEM_AW         = 12,
  parameter int READ_LATENCY   = 2,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  sdram_responder_if.slave   sdram
);

  // One counter serves both states, so size it for the longer of the two windows.
  localparam int CNT_MAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {
    SERVE   = 1'b0,
    REFRESH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               waitreq_q;

  // ---------------------------------------------------------------------------
  // Refresh scheduler
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      SERVE: begin
        if (cnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
          state_d = REFRESH;
          cnt_d   = '0;
        end
      end
      REFRESH: begin
        if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
          state_d = SERVE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SERVE;
        cnt_d   = '0;
      end
    endcase
  end

  // waitrequest is flopped from the next state, so it is a clean register
  // output that tracks the state exactly one-for-one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= SERVE;
      cnt_q     <= '0;
      waitreq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      waitreq_q <= (state_d == REFRESH);
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              rd_acc;
  logic              wr_acc;
  logic              both_err;
  logic              addr_oor;
  logic [MEM_AW-1:0] idx;

  assign addr_oor = |sdram.address_sdram[25:MEM_AW];
  assign idx      = sdram.address_sdram[MEM_AW-1:0];
  assign rd_acc   =  sdram.sdram_read_en & ~sdram.sdram_write_en & ~waitreq_q;
  assign wr_acc   = ~sdram.sdram_read_en &  sdram.sdram_write_en & ~waitreq_q;
  // Conflicting strobes perform no access at all, in or out of range.
  assign both_err =  sdram.sdram_read_en &  sdram.sdram_write_en & ~waitreq_q;

  // ---------------------------------------------------------------------------
  // Word memory (contents survive reset)
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (wr_acc && !addr_oor) begin
      mem_q[idx] <= sdram.writeData_sdram;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 0 captures at acceptance, last stage drives the port.
  // Out-of-range reads carry zero data but a normal valid bit.
  // ---------------------------------------------------------------------------
  logic [READ_LATENCY-1:0] stg_vld_q, stg_vld_d;
  logic [31:0]             stg_dat_q [READ_LATENCY];
  logic [31:0]             stg_dat_d [READ_LATENCY];

  always_comb begin
    stg_vld_d    = '0;
    stg_dat_d[0] = addr_oor ? 32'h0 : mem_q[idx];
    stg_vld_d[0] = rd_acc;
    for (int i = 1; i < READ_LATENCY; i++) begin
      stg_vld_d[i] = stg_vld_q[i-1];
      stg_dat_d[i] = stg_dat_q[i-1];
    end
    // The output stage only loads with a live word, so data_sdram holds its
    // last value between pulses.
    if (!stg_vld_d[READ_LATENCY-1]) begin
      stg_dat_d[READ_LATENCY-1] = stg_dat_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stg_vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        stg_dat_q[i] <= '0;
      end
    end else begin
      stg_vld_q <= stg_vld_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        stg_dat_q[i] <= stg_dat_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic [1:0] err_q, err_d;

  assign err_d = err_q | {((rd_acc | wr_acc) & addr_oor), both_err};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sdram.data_sdram          = stg_dat_q[READ_LATENCY-1];
  assign sdram.sdram_datareadvalid = stg_vld_q[READ_LATENCY-1];
  assign sdram.waitrequest         = waitreq_q;
  assign sdram.err                 = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: three instances (read latency 1, 2, 8) share one stimulus stream.
// Latency: expected read words are scheduled at acceptance cycle + latency of each instance.
// Backpressure: refresh windows are predicted from the cycle count since reset.
module tb_sdram_responder;
  localparam int P  = 16;
  localparam int R  = 4;
  localparam int NI = 3;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  logic        clk   = 1'b0;
  logic        n_rst = 1'b0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic [25:0] addr  = '0;
  logic [31:0] wdat  = '0;

  logic [31:0] dat_o [NI];
  logic        dv_o  [NI];
  logic        wq_o  [NI];
  logic [1:0]  err_o [NI];

  int edge_cnt = 0;
  int rst_edge = 0;
  int n_chk    = 0;
  int n_fail   = 0;

  // Reference model: plain word array, sticky error pair, per-instance scoreboards.
  logic [31:0] mmem [4096];
  logic [1:0]  merr = 2'b00;
  exp_t        sb [NI][$];

  function automatic int lat(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 8;
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      sdram_responder_if ifc ();
      assign ifc.sdram_read_en   = rd;
      assign ifc.sdram_write_en  = wr;
      assign ifc.address_sdram   = addr;
      assign ifc.writeData_sdram = wdat;
      assign dat_o[g] = ifc.data_sdram;
      assign dv_o[g]  = ifc.sdram_datareadvalid;
      assign wq_o[g]  = ifc.waitrequest;
      assign err_o[g] = ifc.err;

      sdram_responder #(
        .MEM_AW         (12),
        .READ_LATENCY   ((g == 0) ? 1 : (g == 1) ? 2 : 8),
        .REFRESH_PERIOD (P),
        .REFRESH_CYCLES (R)
      ) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .sdram (ifc)
      );
    end
  endgenerate

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [lat=%0d] t=%0t got %h expected %h", nm, lat(g), $time, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle; cycle c is the interval after edge c since reset release.
  always @(negedge clk) begin
    int   c;
    exp_t e;
    if (n_rst) begin
      c = edge_cnt - rst_edge;
      for (int g = 0; g < NI; g++) begin
        chk("waitrequest", g, 32'(wq_o[g]), 32'((c % (P + R)) >= P));
        chk("err", g, 32'(err_o[g]), 32'(merr));
        if (dv_o[g]) begin
          if (sb[g].size() == 0) begin
            chk("unexpected_valid", g, 32'(dv_o[g]), 32'd0);
          end else begin
            e = sb[g].pop_front();
            chk("rd_data", g, dat_o[g], e.dat);
            chk("rd_cycle", g, 32'(c), 32'(e.due));
          end
        end else if (sb[g].size() != 0 && sb[g][0].due <= c) begin
          chk("missing_valid", g, 32'(dv_o[g]), 32'd1);
          void'(sb[g].pop_front());
        end
      end
    end
  end

  // One cycle of stimulus; the model decides acceptance from the refresh schedule.
  task automatic drive_cycle(input logic r, input logic w, input logic [25:0] a,
                             input logic [31:0] d, output bit acc);
    int          c;
    logic        oor;
    logic [31:0] v;
    exp_t        e;
    c    = edge_cnt - rst_edge;
    rd   = r;
    wr   = w;
    addr = a;
    wdat = d;
    acc  = (c % (P + R)) < P;
    @(posedge clk);
    #1;
    rd  = 1'b0;
    wr  = 1'b0;
    oor = (a[25:12] != 14'd0);
    if (acc) begin
      if (r && w) begin
        merr[0] = 1'b1;
      end else if (w) begin
        if (oor) merr[1] = 1'b1;
        else     mmem[a[11:0]] = d;
      end else if (r) begin
        if (oor) merr[1] = 1'b1;
        v = oor ? 32'h0 : mmem[a[11:0]];
        for (int g = 0; g < NI; g++) begin
          e.due = c + lat(g);
          e.dat = v;
          sb[g].push_back(e);
        end
      end
    end
  endtask

  // Reissue until the request is taken (at most one refresh window of retries).
  task automatic op(input logic r, input logic w, input logic [25:0] a, input logic [31:0] d);
    bit acc;
    int n;
    n = 0;
    do begin
      drive_cycle(r, w, a, d, acc);
      n++;
    end while (!acc && n < 10);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 26'd0, 32'd0, acc);
  endtask

  // Short asynchronous reset pulse inside the current cycle.
  task automatic do_reset();
    #1 n_rst = 1'b0;
    #2 n_rst = 1'b1;
    rst_edge = edge_cnt;
    merr     = 2'b00;
    for (int g = 0; g < NI; g++) sb[g].delete();
    for (int g = 0; g < NI; g++) begin
      chk("rst_data", g, dat_o[g], 32'h0);
      chk("rst_valid", g, 32'(dv_o[g]), 32'd0);
      chk("rst_waitrequest", g, 32'(wq_o[g]), 32'd0);
      chk("rst_err", g, 32'(err_o[g]), 32'd0);
    end
  endtask

  initial begin
    bit          acc;
    int          k;
    logic [25:0] a;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Write then read at address 10 on edges 1 and 2.
    op(1'b0, 1'b1, 26'd10, 32'hA5A5_0001);
    op(1'b1, 1'b0, 26'd10, 32'h0);
    idle(10);

    // Fill low addresses: 0..7 get 100+n, the rest random.
    for (int n = 0; n < 16; n++) begin
      op(1'b0, 1'b1, 26'(n), (n < 8) ? 32'(100 + n) : $urandom);
    end

    // Eight back-to-back reads right after reset, clear of any refresh window.
    do_reset();
    for (int n = 0; n < 8; n++) op(1'b1, 1'b0, 26'(n), 32'h0);
    idle(10);

    // Hold read_en through the first refresh window.
    do_reset();
    for (int n = 0; n < 30; n++) drive_cycle(1'b1, 1'b0, 26'd5, 32'h0, acc);
    idle(10);

    // Reset between acceptance and valid: nothing must come out, schedule restarts.
    do_reset();
    op(1'b1, 1'b0, 26'd4, 32'h0);
    do_reset();
    idle(25);

    // Error cases.
    do_reset();
    op(1'b1, 1'b1, 26'd3, 32'hDEAD_BEEF);
    idle(2);
    op(1'b1, 1'b0, 26'd3, 32'h0);
    op(1'b0, 1'b1, 26'h100_0000, 32'h1234_5678);
    op(1'b1, 1'b0, 26'h100_0000, 32'h0);
    idle(10);

    // Random traffic, including reads and writes issued into refresh windows.
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 19);
      if ($urandom_range(0, 9) == 0) a = {14'($urandom_range(1, 16383)), 12'($urandom_range(0, 15))};
      else                           a = 26'($urandom_range(0, 15));
      if (k < 8)       drive_cycle(1'b1, 1'b0, a, 32'h0, acc);
      else if (k < 16) drive_cycle(1'b0, 1'b1, a, $urandom, acc);
      else if (k < 17) drive_cycle(1'b1, 1'b1, a, $urandom, acc);
      else             drive_cycle(1'b0, 1'b0, a, 32'h0, acc);
    end
    idle(12);

    for (int g = 0; g < NI; g++) chk("drain", g, 32'(sb[g].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_responder.md
# sdram_responder

Slave-side responder for the custom-logic SDRAM master port. It accepts the one-cycle read and write strobes, the word address and the write data from the filter pipeline. Writes go into an internal word memory. Each read returns one data word with a single-cycle valid pulse after a fixed latency. A periodic refresh window holds off new requests, so the bench and integration can exercise the master's stall and latency handling without the real SDRAM controller.

## Interface
Parameters:
- MEM_AW, 12: internal memory address bits; depth is 2^MEM_AW 32-bit words.
- READ_LATENCY, 2: cycles from read acceptance to data valid; legal range 1..8.
- REFRESH_PERIOD, 256: cycles of SERVE between refresh windows; must be at least 2.
- REFRESH_CYCLES, 4: length of each refresh window in cycles; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- n_rst  in  1  reset, asynchronous and active-low; one clock, no other clock domain.
- sdram_read_en  in  1  read request strobe.
- sdram_write_en  in  1  write request strobe.
- address_sdram  in  26  word address.
- writeData_sdram  in  32  write data.
- data_sdram  out  32  read data.
- sdram_datareadvalid  out  1  one-cycle pulse; data_sdram is valid while it is high.
- waitrequest  out  1  high means requests are not accepted this cycle.
- err  out  2  sticky errors: bit0 = read_en and write_en both high; bit1 = address out of range.

## Operation
- Request acceptance:
  - A read is accepted on an edge where read_en=1, write_en=0 and waitrequest=0.
  - A write is accepted on an edge where write_en=1, read_en=0 and waitrequest=0.
  - Any strobe present while waitrequest=1 is ignored: it is not queued and sets no error. The master must hold or reissue it.
- Both strobes high with waitrequest=0: no access takes place and err[0] is set.
- Range check: address_sdram[25:MEM_AW] != 0 counts as out of range.
  - An out-of-range write is dropped and sets err[1].
  - An out-of-range read sets err[1] and still returns a word, with data 32'h0 and a normal valid pulse.
- Memory:
  - Word-addressed, using address_sdram[MEM_AW-1:0].
  - An accepted write updates the memory at its acceptance edge.
  - Memory contents are not cleared by reset.
- Read pipeline:
  - A READ_LATENCY-deep shift register carries a valid bit and the captured data or zero flag.
  - Memory is read at the acceptance edge, so a write accepted at edge k is visible to a read accepted at edge k+1 or later.
  - A read may be accepted on every cycle. Data returns strictly in acceptance order.
- State machine, two states:
  - SERVE:
    - waitrequest=0.
    - A cycle counter counts 0..REFRESH_PERIOD-1.
    - At the edge where the count equals REFRESH_PERIOD-1, go to REFRESH and clear the counter.
  - REFRESH:
    - waitrequest=1.
    - The counter counts 0..REFRESH_CYCLES-1.
    - At the edge where the count equals REFRESH_CYCLES-1, go to SERVE and clear the counter.
  - Reads already in the pipeline keep advancing and complete during REFRESH.
- err bits are sticky; only n_rst clears them.

## Timing
- Reset (n_rst=0, asynchronous) forces:
  - data_sdram=0, sdram_datareadvalid=0, waitrequest=0, err=0.
  - State SERVE, counter 0, all pipeline valid bits 0.
- Reset mid-operation discards every in-flight read; no valid pulse follows it.
- waitrequest is registered and depends only on state, so it is glitch-free and can be sampled by the master in the same cycle it is driven.
- Read latency: for a read accepted at edge k, sdram_datareadvalid=1 and data_sdram holds the word from edge k+READ_LATENCY-1 to edge k+READ_LATENCY. The master samples it at edge k+READ_LATENCY.
- When no valid pulse is present, data_sdram holds its last value.
- Throughput: one request per cycle while in SERVE. The first refresh window starts REFRESH_PERIOD cycles after reset is released.

## Test plan
- Write then read, READ_LATENCY=2:
  - Stimulus: write 32'hA5A5_0001 to address 10 at edge 1; read address 10 at edge 2.
  - Required: datareadvalid high only between edges 3 and 4, with data_sdram=32'hA5A5_0001.
- Back-to-back reads:
  - Stimulus: write addresses 0..7 with values 100+n; then issue 8 reads on consecutive cycles.
  - Required: 8 consecutive valid pulses with data 100..107 in order; no gaps.
- Refresh stall, REFRESH_PERIOD=16, REFRESH_CYCLES=4:
  - Stimulus: hold read_en=1 continuously after reset.
  - Required: waitrequest high for cycles 16..19; reads issued there are not accepted; the two reads in flight still return; acceptance resumes at cycle 20.
- Errors:
  - Stimulus: assert both strobes at address 3.
  - Required: err=2'b01; memory unchanged; no valid pulse.
  - Stimulus: write then read address 26'h100_0000.
  - Required: err=2'b11; the read returns 32'h0 with a valid pulse.
- Reset mid-flight:
  - Stimulus: pulse n_rst low between the acceptance edge of a read and its valid edge.
  - Required: no valid pulse; err=0; waitrequest=0; the refresh counter restarts from 0.
- Latency sweep: repeat the first test with READ_LATENCY=1 and READ_LATENCY=8; required: the valid pulse lands exactly 1 and 8 cycles after acceptance.
